// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers:
// per-stage payload widths, control-field layout and handshake states.
package pipe_pkg;

    // Datapath payload width for each stage boundary
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_DATA_W  = 148;
    localparam int unsigned EX_MEM_DATA_W = 133;
    localparam int unsigned MEM_WB_DATA_W = 101;

    // Control payload layout
    localparam int unsigned CTRL_W         = 12;
    localparam int unsigned CTRL_REGDST    = 11;
    localparam int unsigned CTRL_JUMP      = 10;
    localparam int unsigned CTRL_BRANCH    = 9;
    localparam int unsigned CTRL_MEMREAD   = 8;
    localparam int unsigned CTRL_MEMTOREG  = 7;
    localparam int unsigned CTRL_MEMWRITE  = 6;
    localparam int unsigned CTRL_ALUSRC    = 5;
    localparam int unsigned CTRL_REGWRITE  = 4;
    localparam int unsigned CTRL_ALUOP_MSB = 3;
    localparam int unsigned CTRL_ALUOP_LSB = 0;

    // All control bits low: no register or memory write, safe bubble
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // Occupancy of the stage register: main only, main+skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of the stage register: valid flag, datapath and control
// payload. Clear kills the slot and zeroes its control bits; data is left stale.
module pipe_skid_entry #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);
    import pipe_pkg::*;

    // Slot register: clear wins over load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a 2-entry skid
// buffer (main drives the outputs, skid absorbs one beat of back-pressure),
// synchronous flush to a NOP bubble and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipe_pkg::*;

    stage_state_t      state, state_next;
    logic              accept, drain;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

    // in_ready comes straight from the skid flop, so out_ready never reaches it
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_W'(CTRL_NOP);

    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_next;
    end

    // Next occupancy and slot load/clear strobes; flush overrides everything
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load  = 1'b1;
                        state_next = ST_FULL;
                    end else if (drain) begin
                        main_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_skid_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .d_data  (main_d_data),
        .d_ctrl  (main_d_ctrl),
        .q_valid (main_valid),
        .q_data  (main_data),
        .q_ctrl  (main_ctrl)
    );

    pipe_skid_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
    );

    // Saturating count of stalled cycles; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, checked
// against a queue-based model of a 2-deep FIFO with flush and a stall counter.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 12;
    localparam int unsigned NW = 4;
    localparam int unsigned SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t       mq[$];
    int unsigned m_stall;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic exp_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic exp_ready();
        return mq.size() < 2;
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        return (mq.size() > 0) ? mq[0].c : '0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (mq.size() > 0) ? mq[0].d : '0;
    endfunction

    function automatic logic [NW-1:0] exp_stall();
        return NW'(m_stall);
    endfunction

    // Advance the model by one edge using the currently driven inputs,
    // then clock the DUT and settle 1 time unit after the edge.
    task automatic step();
        bit acc, drn;
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        if ((mq.size() > 0) && !out_ready && (m_stall < SAT)) m_stall++;
        if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back('{d: in_data, c: in_ctrl});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = rand_data();
            in_ctrl = CW'($urandom);
            step();
        end
        #2;
        rst_n = 1'b0;
        mq.delete();
        m_stall = 0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (out_ctrl !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_async_payload: got ctrl %h data %h expected 0", out_ctrl, out_data);
        end
        vectors++;
        if (in_ready !== 1'b1 || stall_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_async_ready_cnt: got ready %b cnt %0d expected 1 0", in_ready, stall_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || stall_cnt !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: got valid %b ctrl %h ready %b cnt %0d expected 0 000 1 0",
                         out_valid, out_ctrl, in_ready, stall_cnt);
            end
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d        = DW'(32'h0040_0000 + k * 4);
            c        = CW'($urandom);
            in_valid = 1'b1;
            in_data  = d;
            in_ctrl  = c;
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== d || out_ctrl !== c) begin
                miscompares++;
                $display("FAIL stream_k%0d: got v %b data %h ctrl %h expected 1 %h %h",
                         k, out_valid, out_data, out_ctrl, d, c);
            end
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready_k%0d: got %b expected 1", k, in_ready);
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            miscompares++;
            $display("FAIL stream_tail_bubble: got v %b ctrl %h expected 0 000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_back_pressure();
        logic [NW-1:0] want_cnt [4];
        want_cnt[0] = NW'(0);
        want_cnt[1] = NW'(1);
        want_cnt[2] = NW'(2);
        want_cnt[3] = NW'(3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      in_data = DW'(8'h11);
            else if (i == 1) in_data = DW'(8'h22);
            else             in_valid = 1'b0;
            in_ctrl = CW'($urandom);
            step();
            vectors++;
            if (out_data !== DW'(8'h11) || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got v %b data %h expected 1 11", i, out_valid, out_data);
            end
            vectors++;
            if (stall_cnt !== want_cnt[i] || stall_cnt !== exp_stall()) begin
                miscompares++;
                $display("FAIL bp_cnt_%0d: got %0d expected %0d", i, stall_cnt, want_cnt[i]);
            end
            vectors++;
            if (in_ready !== (i == 0)) begin
                miscompares++;
                $display("FAIL bp_ready_%0d: got %b expected %b", i, in_ready, (i == 0));
            end
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== DW'(8'h22) || out_ctrl !== exp_ctrl()) begin
            miscompares++;
            $display("FAIL bp_drain_second: got v %b data %h ctrl %h expected 1 22 %h",
                     out_valid, out_data, out_ctrl, exp_ctrl());
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== NW'(3)) begin
            miscompares++;
            $display("FAIL bp_drain_done: got v %b ready %b cnt %0d expected 0 1 3",
                     out_valid, in_ready, stall_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = rand_data();
            in_ctrl = CW'($urandom);
            step();
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_full_ready: got %b expected 0", in_ready);
        end
        flush   = 1'b1;
        in_data = rand_data();
        in_ctrl = 12'hFFF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_bubble: got v %b ctrl %h ready %b expected 0 000 1",
                     out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || out_ctrl !== '0) begin
                miscompares++;
                $display("FAIL flush_dropped_%0d: got v %b ctrl %h expected 0 000", i, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_data();
        in_ctrl   = CW'($urandom);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        vectors++;
        if (stall_cnt !== NW'(SAT) || stall_cnt !== exp_stall()) begin
            miscompares++;
            $display("FAIL sat_cnt: got %0d expected %0d", stall_cnt, SAT);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if (stall_cnt !== NW'(SAT) || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_after_flush: got cnt %0d v %b expected %0d 0", stall_cnt, out_valid, SAT);
        end
    endtask

    task automatic test_drain_accept();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand_data();
        in_ctrl   = CW'($urandom);
        step();
        in_data = DW'(8'hAB);
        in_ctrl = CW'($urandom);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== DW'(8'hAB) || out_ctrl !== in_ctrl) begin
            miscompares++;
            $display("FAIL da_payload: got v %b data %h ctrl %h expected 1 ab %h",
                     out_valid, out_data, out_ctrl, in_ctrl);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL da_ready: got %b expected 1", in_ready);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = rand_data();
            in_ctrl   = CW'($urandom);
            step();
            vectors++;
            if (out_valid !== exp_valid() || in_ready !== exp_ready() || out_ctrl !== exp_ctrl()) begin
                miscompares++;
                $display("FAIL rand_hs_%0d: got v %b r %b c %h expected %b %b %h",
                         i, out_valid, in_ready, out_ctrl, exp_valid(), exp_ready(), exp_ctrl());
            end
            vectors++;
            if ((exp_valid() && out_data !== exp_data()) || stall_cnt !== exp_stall()) begin
                miscompares++;
                $display("FAIL rand_data_%0d: got d %h cnt %0d expected %h %0d",
                         i, out_data, stall_cnt, exp_data(), exp_stall());
            end
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_stall   = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_drain_accept();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the MIPS datapath. It is the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It adds:
- valid/ready handshake
- a 2-entry skid buffer, so back-pressure does not create a combinational ready path
- synchronous flush that inserts a NOP bubble
- a saturating stall counter for performance monitoring

Each stage boundary instantiates one copy, with widths set per stage.

Parameters:
DATA_W, 96, width of the datapath payload (pc, operands, immediates, addresses concatenated by the instantiating stage)
CTRL_W, 12, width of the control payload (RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, AluSrc, RegWrite, AluOp[3:0]); zeroed on flush/bubble
CNT_W, 16, width of the stall counter

Ports:
clk, input, 1, stage clock; all state updates on rising edge
rst_n, input, 1, asynchronous active-low reset
in_valid, input, 1, upstream stage presents a valid instruction
in_ready, output, 1, this register can accept; driven from a flop only
in_data, input, DATA_W, upstream datapath payload
in_ctrl, input, CTRL_W, upstream control payload
flush, input, 1, synchronous kill of all held entries (branch/jump taken)
out_valid, output, 1, downstream payload valid
out_ready, input, 1, downstream stage accepts
out_data, output, DATA_W, registered datapath payload
out_ctrl, output, CTRL_W, registered control payload; all-zero whenever out_valid=0
stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst_n=0, async): main and skid entries invalid, data and ctrl zero. in_ready=1, out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0. Deassertion takes effect at the next rising edge.
- Storage: main entry drives the outputs directly. Skid entry holds one overflow beat.
- in_ready = NOT skid_valid, registered.
- Latency: 1 cycle. A beat accepted at edge N is visible on out_* after edge N.
- Accept: in_valid AND in_ready at an edge. Drain: out_valid AND out_ready at an edge.
- State transitions (states EMPTY, ONE, FULL = main only, main+skid):
  - EMPTY + accept -> ONE; main <= in.
  - ONE + accept + drain -> ONE; main <= in.
  - ONE + accept, no drain -> FULL; skid <= in; in_ready falls next cycle.
  - ONE + drain, no accept -> EMPTY.
  - FULL + drain -> ONE; main <= skid. No accept is possible in FULL because in_ready=0.
  - FULL, no drain -> hold; main and skid stable.
- Stability rule: while out_valid=1 and out_ready=0, out_data and out_ctrl do not change.
- Flush has priority over everything:
  - Next state EMPTY; main and skid ctrl <= 0; valids <= 0; in_ready <= 1.
  - A beat offered in the same cycle is dropped.
  - Data fields may keep stale values. out_ctrl must read 0.
- Bubble rule: out_ctrl is forced to 0 whenever out_valid=0. Downstream RegWrite and MemWrite are therefore never asserted for a bubble.
- stall_cnt: increments each edge with out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, is not cleared by flush, and is cleared only by reset.
- Reset mid-operation: both entries are discarded immediately and asynchronously; outputs take their reset values without waiting for a clock.
- Legacy mode: out_ready tied to 1 and flush tied to 0 reproduces the old fixed-register timing (1-cycle pass-through, every cycle).

Decomposition:
- Shared package pipe_pkg:
  - per-stage width localparams (IF_ID_DATA_W=64, ID_EX_DATA_W=148, EX_MEM_DATA_W=133, MEM_WB_DATA_W=101)
  - CTRL_W=12
  - control-field bit indices (CTRL_REGWRITE, CTRL_MEMWRITE, CTRL_ALUOP_LSB, ...)
  - constant CTRL_NOP = 0
- Sub-module pipe_skid_entry: one valid+data+ctrl flop group with load, clear and async reset. It is instantiated twice (main, skid), and the top contains only the handshake FSM and the counter.

Test Plan:
1. Reset: pulse rst_n low for 3 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1. Outputs go to reset values before the next edge.
2. Streaming: out_ready=1, in_data = 32'h00400000 plus k*4 on consecutive cycles -> out_data equals in_data delayed exactly 1 cycle, and in_ready stays 1.
3. Back-pressure: accept A=0x11, B=0x22 with out_ready=0 -> in_ready=0 after B, out_data holds 0x11 and stall_cnt counts 1,2,3. Then raise out_ready -> 0x11 then 0x22 drain in order, with no loss or duplication.
4. Flush: flush=1 while FULL and in_valid=1 with in_ctrl=12'hFFF -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the offered beat never appears.
5. Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15. Then flush -> stall_cnt stays 15.
6. Simultaneous drain+accept in ONE: out_ready=1, in_valid=1, in_data=0xAB -> stays ONE with out_data=0xAB next cycle, and in_ready remains 1.
